// File: rtl/ball_trajectory_ctrl_if.sv
// Shot/render bus between the shot-input logic, ball_trajectory_ctrl and pixel_Gen.
// master = requester side (drives pixel counters and launch), slave = controller.
interface ball_trajectory_ctrl_if;
    logic               p_tick;
    logic [9:0]         pixel_x;
    logic [9:0]         pixel_y;
    logic               launch;
    logic               clear;
    logic signed [9:0]  vx0;
    logic signed [9:0]  vy0;
    logic [9:0]         ball_x;
    logic [9:0]         ball_y;
    logic               busy;
    logic               done;

    modport master (
        output p_tick, pixel_x, pixel_y, launch, clear, vx0, vy0,
        input  ball_x, ball_y, busy, done
    );

    modport slave (
        input  p_tick, pixel_x, pixel_y, launch, clear, vx0, vy0,
        output ball_x, ball_y, busy, done
    );
endinterface

// File: rtl/ball_trajectory_ctrl.sv
// Frame-synchronous projectile sequencer for the pixel_Gen ball position (Q12.4 state).
// Optional feature: define BALL_BOUNCE_EN to rebound off the floor instead of landing.
module ball_trajectory_ctrl #(
    parameter int START_X = 10,
    parameter int START_Y = 300,
    parameter int FLOOR_Y = 440,
    parameter int GRAVITY = 4
) (
    input  logic                  CLK25MHZ,
    input  logic                  reset,
    ball_trajectory_ctrl_if.slave bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_FLIGHT = 2'd2;
    localparam logic [1:0] S_LANDED = 2'd3;

    localparam logic signed [15:0] X0      = 16'(START_X * 16);
    localparam logic signed [15:0] Y0      = 16'(START_Y * 16);
    localparam logic signed [15:0] FLOOR_P = 16'(FLOOR_Y * 16);
    localparam logic signed [15:0] XMAX_P  = 16'(639 * 16);

    logic [1:0]         state_q, state_d;
    logic signed [15:0] px_q, px_d, py_q, py_d;
    logic signed [11:0] vx_q, vx_d, vy_q, vy_d;
    logic               done_q, done_d;

    logic               frame_tick;
    logic signed [15:0] px_n, py_n;
    logic signed [11:0] vy_n;
    logic               y_hit, x_lo, x_hi, land;

    function automatic logic signed [11:0] sat_gravity(input logic signed [11:0] v);
        logic signed [12:0] s;
        s = 13'(v) + 13'(GRAVITY);
        if (s > 13'sd2047)
            return 12'sd2047;
        else if (s < -13'sd2048)
            return -12'sd2048;
        else
            return s[11:0];
    endfunction

    assign frame_tick = bus.p_tick && (bus.pixel_x == 10'd639) && (bus.pixel_y == 10'd479);

    assign px_n  = px_q + 16'(vx_q);
    assign py_n  = py_q + 16'(vy_q);
    assign vy_n  = sat_gravity(vy_q);
    assign y_hit = (py_n >= FLOOR_P);
    assign x_lo  = (px_n < 16'sd0);
    assign x_hi  = (px_n > XMAX_P);

`ifdef BALL_BOUNCE_EN
    logic signed [11:0] vy_half;
    logic               bounce_dead;
    assign vy_half     = vy_q >>> 1;
    assign bounce_dead = (vy_half > -12'sd16) && (vy_half < 12'sd16);
`endif

    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        done_d  = 1'b0;
        land    = 1'b0;

        case (state_q)
            S_IDLE: begin
                px_d = X0;
                py_d = Y0;
                if (bus.launch) begin
                    vx_d    = 12'(bus.vx0);
                    vy_d    = 12'(bus.vy0);
                    state_d = S_ARMED;
                end
            end
            S_ARMED, S_FLIGHT: begin
                if (frame_tick) begin
                    px_d    = px_n;
                    py_d    = py_n;
                    vy_d    = vy_n;
                    state_d = S_FLIGHT;
                    if (y_hit) begin
                        py_d = FLOOR_P;
`ifdef BALL_BOUNCE_EN
                        // Rebound with half the impact speed until it is too slow to bounce.
                        vy_d = -vy_half;
                        land = bounce_dead;
`else
                        land = 1'b1;
`endif
                    end
                    if (x_lo) begin
                        px_d = 16'sd0;
                        land = 1'b1;
                    end else if (x_hi) begin
                        px_d = XMAX_P;
                        land = 1'b1;
                    end
                    if (land) begin
                        state_d = S_LANDED;
                        done_d  = 1'b1;
                    end
                end
            end
            S_LANDED: begin
                if (bus.launch) begin
                    px_d    = X0;
                    py_d    = Y0;
                    vx_d    = 12'(bus.vx0);
                    vy_d    = 12'(bus.vy0);
                    state_d = S_ARMED;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // clear overrides any launch or frame update in the same cycle
        if (bus.clear) begin
            state_d = S_IDLE;
            px_d    = X0;
            py_d    = Y0;
            vx_d    = 12'sd0;
            vy_d    = 12'sd0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK25MHZ or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            px_q    <= X0;
            py_q    <= Y0;
            vx_q    <= 12'sd0;
            vy_q    <= 12'sd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            done_q  <= done_d;
        end
    end

    assign bus.ball_x = px_q[13:4];
    assign bus.ball_y = py_q[13:4];
    assign bus.busy   = (state_q == S_ARMED) || (state_q == S_FLIGHT);
    assign bus.done   = done_q;

endmodule

// File: tb/tb_ball_trajectory_ctrl.sv
// Directed bench for ball_trajectory_ctrl: hand anchors plus a frame-by-frame projectile model.
module tb_ball_trajectory_ctrl;

    logic CLK25MHZ;
    logic reset;
    int   total;
    int   bad;
    int   mpx, mpy, mvx, mvy;
    int   frames;

    ball_trajectory_ctrl_if ifc ();

    ball_trajectory_ctrl dut (
        .CLK25MHZ (CLK25MHZ),
        .reset    (reset),
        .bus      (ifc.slave)
    );

    initial CLK25MHZ = 1'b0;
    always #20 CLK25MHZ = ~CLK25MHZ;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK25MHZ);
        #1;
    endtask

    task automatic tick();
        ifc.p_tick  = 1'b1;
        ifc.pixel_x = 10'd639;
        ifc.pixel_y = 10'd479;
        step();
        ifc.pixel_x = 10'd0;
        ifc.pixel_y = 10'd0;
    endtask

    // near-miss strobes that must not advance the ball
    task automatic idle_cycles();
        ifc.p_tick  = 1'b1;
        ifc.pixel_x = 10'd639;
        ifc.pixel_y = 10'd478;
        step();
        ifc.p_tick  = 1'b0;
        ifc.pixel_y = 10'd479;
        step();
        ifc.p_tick  = 1'b1;
        ifc.pixel_x = 10'd0;
        ifc.pixel_y = 10'd0;
    endtask

    task automatic model_step(output bit land);
        int npx, npy, old_vy;
        old_vy = mvy;
        npx = mpx + mvx;
        npy = mpy + mvy;
        mvy = (mvy + 4 > 2047) ? 2047 : mvy + 4;
        mpx = npx;
        mpy = npy;
        land = 1'b0;
        if (npy >= 440 * 16) begin
            mpy = 440 * 16;
`ifdef BALL_BOUNCE_EN
            if ((old_vy >>> 1) > -16 && (old_vy >>> 1) < 16) land = 1'b1;
            else mvy = -(old_vy >>> 1);
`else
            land = 1'b1;
`endif
        end
        if (npx < 0) begin
            mpx = 0;
            land = 1'b1;
        end else if (npx > 639 * 16) begin
            mpx = 639 * 16;
            land = 1'b1;
        end
    endtask

    task automatic run_flight(input int max_frames, input int relaunch_at, output int n);
        bit land;
        land = 1'b0;
        n = 0;
        while (!land && n < max_frames) begin
            if (n == relaunch_at) begin
                ifc.vx0    = -10'sd100;
                ifc.vy0    = 10'sd50;
                ifc.launch = 1'b1;
                step();
                ifc.launch = 1'b0;
                chk("relaunch_busy", int'(ifc.busy), 1);
            end
            idle_cycles();
            chk("hold_y", int'(ifc.ball_y), (mpy >> 4) & 1023);
            tick();
            model_step(land);
            n++;
            chk("fl_x", int'(ifc.ball_x), (mpx >> 4) & 1023);
            chk("fl_y", int'(ifc.ball_y), (mpy >> 4) & 1023);
            chk("fl_done", int'(ifc.done), int'(land));
            chk("fl_busy", int'(ifc.busy), int'(!land));
        end
        chk("flight_landed", int'(land), 1);
        step();
        chk("done_one_cycle", int'(ifc.done), 0);
    endtask

    task automatic do_launch(input int vx, input int vy);
        ifc.vx0    = 10'(vx);
        ifc.vy0    = 10'(vy);
        ifc.launch = 1'b1;
        step();
        ifc.launch = 1'b0;
        mpx = 160;
        mpy = 4800;
        mvx = vx;
        mvy = vy;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        ifc.p_tick  = 1'b1;
        ifc.pixel_x = 10'd200;
        ifc.pixel_y = 10'd100;
        ifc.launch  = 1'b0;
        ifc.clear   = 1'b0;
        ifc.vx0     = '0;
        ifc.vy0     = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_x", int'(ifc.ball_x), 10);
        chk("rst_y", int'(ifc.ball_y), 300);
        chk("rst_busy", int'(ifc.busy), 0);
        chk("rst_done", int'(ifc.done), 0);
        tick();
        chk("idle_frame_x", int'(ifc.ball_x), 10);
        chk("idle_frame_y", int'(ifc.ball_y), 300);
        chk("idle_frame_done", int'(ifc.done), 0);

        // shot vx0=32, vy0=-64
        do_launch(32, -64);
        chk("armed_busy", int'(ifc.busy), 1);
        chk("armed_y", int'(ifc.ball_y), 300);
        tick();
        chk("f1_x", int'(ifc.ball_x), 12);
        chk("f1_y", int'(ifc.ball_y), 296);
        tick();
        chk("f2_x", int'(ifc.ball_x), 14);
        chk("f2_y", int'(ifc.ball_y), 292);
        mpx = 224;
        mpy = 4676;
        mvy = -56;
        run_flight(400, 5, frames);
`ifndef BALL_BOUNCE_EN
        chk("land_frames", frames, 52);
        chk("land_y", int'(ifc.ball_y), 440);
        chk("land_x", int'(ifc.ball_x), 118);
`endif
        tick();
        chk("landed_hold_x", int'(ifc.ball_x), (mpx >> 4) & 1023);
        chk("landed_hold_busy", int'(ifc.busy), 0);
        chk("landed_hold_done", int'(ifc.done), 0);

        // clear beats a simultaneous launch
        ifc.clear  = 1'b1;
        ifc.launch = 1'b1;
        ifc.vx0    = 10'sd5;
        step();
        ifc.clear  = 1'b0;
        ifc.launch = 1'b0;
        chk("clr_busy", int'(ifc.busy), 0);
        chk("clr_x", int'(ifc.ball_x), 10);
        chk("clr_y", int'(ifc.ball_y), 300);
        tick();
        chk("clr_frame_x", int'(ifc.ball_x), 10);

        // launch coincident with frame_tick only latches velocities
        ifc.vx0    = 10'sd16;
        ifc.vy0    = 10'sd0;
        ifc.launch = 1'b1;
        tick();
        ifc.launch = 1'b0;
        chk("coin_busy", int'(ifc.busy), 1);
        chk("coin_x", int'(ifc.ball_x), 10);
        tick();
        chk("coin_next_x", int'(ifc.ball_x), 11);
        chk("coin_next_y", int'(ifc.ball_y), 300);
        ifc.clear = 1'b1;
        step();
        ifc.clear = 1'b0;
        chk("clr2_x", int'(ifc.ball_x), 10);
        chk("clr2_busy", int'(ifc.busy), 0);

        // left wall on the first update
        do_launch(-400, 0);
        tick();
        chk("lwall_x", int'(ifc.ball_x), 0);
        chk("lwall_y", int'(ifc.ball_y), 300);
        chk("lwall_done", int'(ifc.done), 1);
        chk("lwall_busy", int'(ifc.busy), 0);
        step();
        chk("lwall_done_off", int'(ifc.done), 0);

        // relaunch from LANDED toward the right wall
        do_launch(511, -64);
        chk("reload_x", int'(ifc.ball_x), 10);
        run_flight(40, -1, frames);
        chk("rwall_frames", frames, 20);
        chk("rwall_x", int'(ifc.ball_x), 639);

        // asynchronous reset mid-flight
        do_launch(32, -64);
        tick();
        tick();
        #5 reset = 1'b1;
        #1;
        chk("areset_x", int'(ifc.ball_x), 10);
        chk("areset_y", int'(ifc.ball_y), 300);
        chk("areset_busy", int'(ifc.busy), 0);
        #5 reset = 1'b0;
        step();

`ifdef BALL_BOUNCE_EN
        do_launch(0, 0);
        run_flight(600, -1, frames);
        chk("bounce_y", int'(ifc.ball_y), 440);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
